// File: rtl/id_regfile_fwd.sv
// rtl/id_regfile_fwd.sv - ID-stage register file with WB bypass, EX/MEM forwarding and load-use stall
// Stall counter saturates; register 0 is hardwired to zero.
module id_regfile_fwd #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic          use_rs,
  input  logic          use_rt,
  input  logic          wb_wreg,
  input  logic [AW-1:0] wb_d,
  input  logic [DW-1:0] wdi,
  input  logic          e_wreg,
  input  logic          e_m2reg,
  input  logic [AW-1:0] e_rn,
  input  logic [DW-1:0] ealu,
  input  logic          m_wreg,
  input  logic          m_m2reg,
  input  logic [AW-1:0] m_rn,
  input  logic [DW-1:0] malu,
  input  logic [DW-1:0] mmo,
  output logic [DW-1:0] qa,
  output logic [DW-1:0] qb,
  output logic [1:0]    fwda,
  output logic [1:0]    fwdb,
  output logic          stall,
  output logic [CW-1:0] stall_cnt
);

  localparam int NR = 1 << AW;

  logic [DW-1:0] regs [NR];
  logic [AW-1:0] addr [2];

  assign addr[0] = rs;
  assign addr[1] = rt;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NR; i++) regs[i] <= '0;
    end else if (wb_wreg && wb_d != '0) begin
      regs[wb_d] <= wdi;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DW-1:0] base;
    logic [DW-1:0] q;
    logic [1:0]    fwd;

    always_comb begin
      base = regs[addr[p]];
      if (addr[p] == '0) base = '0;
      else if (wb_wreg && wb_d == addr[p]) base = wdi;

      fwd = 2'b00;
      q   = base;
      // An EX load cannot forward yet; it falls through to MEM or the base value.
      if (addr[p] != '0) begin
        if (e_wreg && !e_m2reg && e_rn == addr[p]) begin
          fwd = 2'b01;
          q   = ealu;
        end else if (m_wreg && m_rn == addr[p]) begin
          fwd = m_m2reg ? 2'b11 : 2'b10;
          q   = m_m2reg ? mmo : malu;
        end
      end
    end
  end

  assign qa   = g_port[0].q;
  assign qb   = g_port[1].q;
  assign fwda = g_port[0].fwd;
  assign fwdb = g_port[1].fwd;

  assign stall = e_wreg & e_m2reg & (e_rn != '0) &
                 ((use_rs & (e_rn == rs)) | (use_rt & (e_rn == rt)));

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != {CW{1'b1}}) begin
      stall_cnt <= stall_cnt + CW'(1);
    end
  end

endmodule

// File: doc/id_regfile_fwd.md
Name: id_regfile_fwd

Overview:
- ID-stage consumer of the write-back interface.
- Holds the 32x32 architectural register file and accepts the WB stage's write (wb_wreg, wb_d, wdi).
- Serves two read ports to decode, with WB-to-ID bypass and EX/MEM forwarding.
- Detects load-use hazards, raises a stall, and counts stall cycles.

Parameters:
- DW, 32, data width of registers and forwarded values.
- AW, 5, register address width (2^AW entries).
- CW, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- clrn  in  1  asynchronous active-low reset.
- rs  in  AW  read address A.
- rt  in  AW  read address B.
- use_rs  in  1  instruction in ID reads rs.
- use_rt  in  1  instruction in ID reads rt.
- wb_wreg  in  1  write enable from WB.
- wb_d  in  AW  write address from WB.
- wdi  in  DW  write data from WB.
- e_wreg  in  1  EX-stage instruction writes a register.
- e_m2reg  in  1  EX-stage instruction is a load.
- e_rn  in  AW  EX destination.
- ealu  in  DW  EX ALU result.
- m_wreg  in  1  MEM-stage instruction writes a register.
- m_m2reg  in  1  MEM-stage instruction is a load.
- m_rn  in  AW  MEM destination.
- malu  in  DW  MEM ALU result.
- mmo  in  DW  MEM memory read data.
- qa  out  DW  forwarded operand A.
- qb  out  DW  forwarded operand B.
- fwda  out  2  source select A: 00 regfile/bypass, 01 EX alu, 10 MEM alu, 11 MEM load data.
- fwdb  out  2  source select B, same encoding as fwda.
- stall  out  1  load-use hazard; ID and IF must hold.
- stall_cnt  out  CW  saturating count of stall cycles.

Behaviour:
- Reset:
  - Asynchronous on clrn=0.
  - All registers 1..31 and stall_cnt go to 0.
  - qa/qb/fwda/fwdb/stall are combinational; with a zero array they read 0 unless forwarding applies.
- Write:
  - On the rising edge of clk, if wb_wreg=1 and wb_d!=0, reg[wb_d] <= wdi.
  - Writes to register 0 are ignored; register 0 always reads 0.
- Read, combinational, zero latency:
  - Base value is reg[rs] (resp. reg[rt]).
  - WB bypass: if wb_wreg=1, wb_d!=0 and wb_d==rs, the base value is wdi, so the register is written and read in the same cycle.
- Forwarding per port, highest priority first, evaluated only when address !=0:
  1. e_wreg=1 and e_rn==addr and e_m2reg=0 -> 01, ealu.
  2. m_wreg=1 and m_rn==addr -> 10 with malu if m_m2reg=0; 11 with mmo if m_m2reg=1.
  3. Otherwise 00 with the bypassed base value.
- Load-use stall:
  - stall = e_wreg & e_m2reg & (e_rn!=0) & ((use_rs & e_rn==rs) | (use_rt & e_rn==rt)).
  - While stall=1, qa/qb are don't-care. fwd selects still follow the rules above, with EX-load matches falling through to lower priorities.
  - use_rs/use_rt=0 suppresses stall for that port but not forwarding.
- stall_cnt:
  - Increments by 1 on each rising edge where stall=1.
  - Saturates at all-ones and does not wrap.
  - Only reset clears it.
- Simultaneous events:
  - EX and MEM both target rs: EX wins.
  - MEM and WB both target rs: MEM wins.
  - Same address on rs and rt: both ports get identical results.
- Reset asserted mid-cycle clears the array immediately; a write on the same edge as reset release is not performed.

Test Plan:
- Reset, then read rs=5, rt=31 -> qa=qb=0, fwda=fwdb=00, stall=0, stall_cnt=0.
- wb_wreg=1, wb_d=7, wdi=0xDEADBEEF, rs=7 in the same cycle -> qa=0xDEADBEEF before the edge; after the edge wb_wreg=0 and qa still reads 0xDEADBEEF. Write wb_d=0 with 0x1234 -> rs=0 reads 0.
- Priority: reg[3]=0x11, m_wreg=1, m_rn=3, malu=0x22, e_wreg=1, e_rn=3, ealu=0x33, rs=rt=3 -> qa=qb=0x33, fwd=01. Drop e_wreg -> 0x22, fwd=10. Set m_m2reg=1, mmo=0x44 -> 0x44, fwd=11.
- Load-use: e_wreg=1, e_m2reg=1, e_rn=9, rt=9, use_rt=1 held for 3 cycles -> stall=1 each cycle, stall_cnt=3. Set use_rt=0 -> stall=0.
- Register-0 guard: e_wreg=1, e_rn=0, e_m2reg=1, rs=0, use_rs=1 -> stall=0, qa=0, fwda=00.
- Saturation: preload via a long stall with CW reduced to 4 -> stall_cnt stops at 15. Assert clrn=0 mid-stall -> stall_cnt=0 and reg[7]=0 immediately, without waiting for a clock edge.
